// File: rtl/noise_excitation.sv
// noise_excitation: LFSR noise shaped by an ADSR envelope, one sample per clkdiv clocks.
module noise_excitation #(
  parameter int unsigned clkdiv = 1134
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gate,
  input  logic [7:0]  attack_rate,
  input  logic [7:0]  decay_rate,
  input  logic [7:0]  sustain_level,
  input  logic [7:0]  release_rate,
  output logic        ena,
  output logic [15:0] q,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;
  localparam logic [15:0] LAST = 16'(clkdiv - 1);
  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d, env_q, env_d, q_q, q_d, target;
  logic [15:0]        a_step, d_step, r_step;
  logic [16:0]        a_sum, d_floor;
  logic [22:0]        lfsr_q, lfsr_d;
  logic               ena_q, ena_d;
  logic signed [31:0] prod;
  always_comb begin
    target  = {sustain_level, sustain_level};
    a_step  = {4'b0, attack_rate, 4'b0};
    d_step  = {4'b0, decay_rate, 4'b0};
    r_step  = {4'b0, release_rate, 4'b0};
    a_sum   = {1'b0, env_q} + {1'b0, a_step};
    d_floor = {1'b0, target} + {1'b0, d_step};
    prod    = $signed(lfsr_q[22:7]) * $signed({1'b0, env_q});
    cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 16'd1;
    ena_d   = cnt_q == LAST;
    lfsr_d  = ena_q ? {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[17]} : lfsr_q;
    q_d     = ena_q ? 16'(prod >>> 16) : q_q;
    state_d = state_q;
    env_d   = env_q;
    if (ena_q) begin
      case (state_q)
        IDLE: begin
          env_d = '0;
          if (gate) state_d = ATTACK;
        end
        ATTACK:
          if (!gate) state_d = RELEASE;
          else if (a_sum >= 17'h0FFFF || attack_rate == 8'd0) begin
            env_d   = 16'hFFFF;
            state_d = DECAY;
          end else env_d = a_sum[15:0];
        DECAY:
          if (!gate) state_d = RELEASE;
          else if ({1'b0, env_q} <= d_floor || decay_rate == 8'd0) begin
            env_d   = target;
            state_d = SUSTAIN;
          end else env_d = env_q - d_step;
        SUSTAIN:
          if (!gate) state_d = RELEASE;
          else env_d = target;
        RELEASE:
          if (gate) state_d = ATTACK;
          else if (env_q <= r_step || release_rate == 8'd0) begin
            env_d   = '0;
            state_d = IDLE;
          end else env_d = env_q - r_step;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      ena_q   <= 1'b0;
      lfsr_q  <= 23'h7FFFFF;
      state_q <= IDLE;
      env_q   <= '0;
      q_q     <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ena_q   <= ena_d;
      lfsr_q  <= lfsr_d;
      state_q <= state_d;
      env_q   <= env_d;
      q_q     <= q_d;
    end
  end
  assign ena  = ena_q;
  assign q    = q_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_noise_excitation.sv
// tb_noise_excitation: randomized scoreboard bench against an arithmetic ADSR/noise reference.
module tb_noise_excitation;
  logic        clk = 1'b0, reset = 1'b1, gate = 1'b0;
  logic [7:0]  attack_rate = 0, decay_rate = 0, sustain_level = 0, release_rate = 0;
  logic        ena, busy;
  logic [15:0] q;
  int errors = 0, checks = 0;
  logic [16:0] exp_q[$];
  int m_state, m_env, m_lfsr;

  noise_excitation #(.clkdiv(4)) dut (
    .clk(clk), .reset(reset), .gate(gate), .attack_rate(attack_rate),
    .decay_rate(decay_rate), .sustain_level(sustain_level),
    .release_rate(release_rate), .ena(ena), .q(q), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0;
    m_env   = 0;
    m_lfsr  = 'h7FFFFF;
  endtask

  // States: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release.
  task automatic model_step(output logic [15:0] eq, output logic eb);
    int noise, sa, sd, sr, tgt;
    longint p;
    noise = (m_lfsr >> 7) & 'hFFFF;
    if (noise >= 32768) noise -= 65536;
    p  = longint'(noise) * longint'(m_env);
    eq = 16'(p >>> 16);
    m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 22) ^ (m_lfsr >> 17)) & 1)) & 'h7FFFFF;
    sa  = attack_rate * 16;
    sd  = decay_rate * 16;
    sr  = release_rate * 16;
    tgt = sustain_level * 257;
    if (gate && (m_state == 0 || m_state == 4)) m_state = 1;
    else if (!gate && m_state >= 1 && m_state <= 3) m_state = 4;
    else if (m_state == 0) m_env = 0;
    else if (m_state == 1) begin
      if (m_env + sa >= 65535 || sa == 0) begin m_env = 65535; m_state = 2; end
      else m_env += sa;
    end else if (m_state == 2) begin
      if (m_env - sd <= tgt || sd == 0) begin m_env = tgt; m_state = 3; end
      else m_env -= sd;
    end else if (m_state == 3) m_env = tgt;
    else begin
      if (m_env <= sr || sr == 0) begin m_env = 0; m_state = 0; end
      else m_env -= sr;
    end
    eb = m_state != 0;
  endtask

  initial begin
    logic [15:0] eq;
    logic        eb;
    int          resets = 0, waited;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int s = 0; s < 2000; s++) begin
      waited = 0;
      forever begin
        @(posedge clk);
        #1;
        if (ena) break;
        if (++waited > 20) break;
      end
      if (!ena) begin
        errors++;
        checks++;
        $display("FAIL ena_timeout: got no ena within %0d cycles, required one every 4", waited);
        break;
      end
      if (s < 30) begin
        gate = 1'b1; attack_rate = 8'hFF; decay_rate = 8'hFF;
        sustain_level = 8'h80; release_rate = 8'h00;
      end else if (s < 40) gate = 1'b0;
      else begin
        if ($urandom_range(0, 24) == 0) gate = ~gate;
        if ($urandom_range(0, 9) == 0) begin
          attack_rate   = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
          decay_rate    = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
          sustain_level = 8'($urandom);
          release_rate  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
        end
      end
      if (m_state == 1 && m_env > 0 && resets < 4 && (resets == 0 || $urandom_range(0, 3) == 0)) begin
        resets++;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        exp_q.delete();
        continue;
      end
      model_step(eq, eb);
      exp_q.push_back({eb, eq});
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic        prev_ena = 1'b0, rst_prev = 1'b0;
    int          gap = 0;
    logic [16:0] e;
    forever begin
      @(negedge clk);
      gap = rst_prev ? 0 : gap + 1;
      if (reset && rst_prev) begin
        checks++;
        if (q !== 16'h0 || busy !== 1'b0 || ena !== 1'b0) begin
          errors++;
          $display("FAIL reset_state: got q=%h busy=%b ena=%b, required 0 0 0", q, busy, ena);
        end
      end
      if (ena && !reset) begin
        checks++;
        if (gap != 4) begin
          errors++;
          $display("FAIL ena_period: got gap %0d cycles, required 4", gap);
        end
        gap = 0;
      end
      if (prev_ena) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL scoreboard_empty: got output with no expectation, required one queued");
        end else begin
          e = exp_q.pop_front();
          checks += 2;
          if (q !== e[15:0]) begin
            errors++;
            $display("FAIL q_sample: got %h, required %h", q, e[15:0]);
          end
          if (busy !== e[16]) begin
            errors++;
            $display("FAIL busy: got %b, required %b", busy, e[16]);
          end
        end
      end
      prev_ena = ena && !reset;
      rst_prev = reset;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by 1000000, required earlier finish");
    $fatal(1, "watchdog expired");
  end
endmodule
